// File: rtl/mem_arbiter_2port.sv
// Round-robin two-port arbiter and access sequencer for the 32x8 banked memory.
// Optional per-port grant counters are enabled with `define MEM_ARB_GRANT_CNT_EN.
module mem_arbiter_2port #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rE,
  output logic                  mem_wE,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
`ifdef MEM_ARB_GRANT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  gnt_cnt0,
  output logic [CNT_WIDTH-1:0]  gnt_cnt1
`endif
);

  if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_err
    $error("mem_arbiter_2port: widths must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t state;
  logic   last_grant;
  logic   g_port;
  logic   g_wr;
  logic   gnt_any;
  logic   gnt_sel;

  // Contention goes to the port that did not win last time.
  always_comb begin
    gnt_any = req0 | req1;
    gnt_sel = (req0 & req1) ? ~last_grant : req1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      g_port      <= 1'b0;
      g_wr        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      mem_rE      <= 1'b0;
      mem_wE      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            g_port      <= gnt_sel;
            g_wr        <= gnt_sel ? wr1 : wr0;
            last_grant  <= gnt_sel;
            // Address/data registers double as the latched request fields.
            mem_address <= gnt_sel ? addr1 : addr0;
            mem_data    <= gnt_sel ? wdata1 : wdata0;
            mem_wE      <= gnt_sel ? wr1 : wr0;
            mem_rE      <= gnt_sel ? ~wr1 : ~wr0;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_rE <= 1'b0;
          mem_wE <= 1'b0;
          if (g_wr) begin
            ack0  <= ~g_port;
            ack1  <= g_port;
            state <= ACK;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata <= mem_dataOut;
          ack0  <= ~g_port;
          ack1  <= g_port;
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_GRANT_CNT_EN
  // Saturating grant counters; they stick at all ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (state == IDLE && gnt_any) begin
      if (!gnt_sel && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + CNT_WIDTH'(1);
      if (gnt_sel && !(&gnt_cnt1))  gnt_cnt1 <= gnt_cnt1 + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed scoreboard bench for mem_arbiter_2port with a behavioural 32x8 memory.
// Build with +define+MEM_ARB_GRANT_CNT_EN to also check the grant counters.
module tb_mem_arbiter_2port;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_rE, mem_wE;
  logic [DW-1:0] rdata, mem_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_dataOut = '0;
`ifdef MEM_ARB_GRANT_CNT_EN
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif

  mem_arbiter_2port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .mem_data(mem_data), .mem_address(mem_address),
    .mem_rE(mem_rE), .mem_wE(mem_wE), .mem_dataOut(mem_dataOut)
`ifdef MEM_ARB_GRANT_CNT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous-read memory model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_wE) mem[mem_address] <= mem_data;
    if (mem_rE) mem_dataOut <= mem[mem_address];
  end

  typedef struct {
    int          port;
    logic        rd;
    logic [DW-1:0] data;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check invariants / scoreboard there.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    chk("rE_wE_exclusive", 32'(mem_rE & mem_wE), 0);
    chk("ack_exclusive", 32'(ack0 & ack1), 0);
    if (ack0 | ack1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'({ack1, ack0}), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack1), e.port);
        if (e.rd) chk("rdata", 32'(rdata), 32'(e.data));
        if (e.exp_cyc >= 0) chk("ack_cycle", cyc, e.exp_cyc);
      end
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int off);
    exp_t e;
    if (p == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    e.port = p; e.rd = !w; e.data = d; e.exp_cyc = (off < 0) ? -1 : cyc + off;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int p, input int bound);
    int k = 0;
    while (k < bound) begin
      tick();
      if (p == 0 ? ack0 : ack1) break;
      k++;
    end
    chk($sformatf("ack%0d_timeout", p), 32'(k < bound), 1);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
    chk("ack_one_cycle", 32'(ack0 | ack1), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic xfer(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(p, w, a, d, w ? 2 : 3);
    wait_ack(p, 10);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack0"}, 32'(ack0), 0);
    chk({tag, "_ack1"}, 32'(ack1), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rE"}, 32'(mem_rE), 0);
    chk({tag, "_wE"}, 32'(mem_wE), 0);
    chk({tag, "_addr"}, 32'(mem_address), 0);
    chk({tag, "_data"}, 32'(mem_data), 0);
  endtask

  logic [AW-1:0] bank_addr [8];
  initial begin
    int k;
    bank_addr = '{5'd0, 5'd7, 5'd8, 5'd15, 5'd16, 5'd23, 5'd24, 5'd31};

    // Reset state
    tick(); tick();
    chk_reset_outs("rst");
`ifdef MEM_ARB_GRANT_CNT_EN
    chk("rst_cnt0", 32'(gnt_cnt0), 0);
    chk("rst_cnt1", 32'(gnt_cnt1), 0);
`endif
    reset = 1'b0;

    // Contention straight after reset: port 0 first, port 1 three cycles later
    issue(0, 1'b1, 5'd3, 8'h11, 2);
    issue(1, 1'b1, 5'd3, 8'h22, 5);
    tick();
    chk("access_busy", 32'(busy), 1);
    chk("access_wE", 32'(mem_wE), 1);
    chk("access_addr", 32'(mem_address), 3);
    chk("access_data", 32'(mem_data), 32'h11);
    wait_ack(0, 10);
    wait_ack(1, 10);
    xfer(0, 1'b0, 5'd3, 8'h22);

    // Write then read back
    xfer(0, 1'b1, 5'd9, 8'hA5);
    xfer(0, 1'b0, 5'd9, 8'hA5);

    // Bank coverage from port 1
    for (int i = 0; i < 8; i++) xfer(1, 1'b1, bank_addr[i], 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) xfer(1, 1'b0, bank_addr[i], 8'h10 + 8'(i));

    // Fairness: continuous writes, last grant was port 1 so port 0 leads
    req0 = 1'b1; wr0 = 1'b1; addr0 = 5'd1; wdata0 = 8'h33;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 5'd2; wdata1 = 8'h44;
    for (int i = 0; i < 20; i++)
      sb.push_back('{port: i % 2, rd: 1'b0, data: 8'h00, exp_cyc: cyc + 2 + 3 * i});
    k = 0;
    for (int t = 0; t < 100 && k < 20; t++) begin
      tick();
      if (ack0 | ack1) k++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("fair_count", k, 20);
    tick(); tick(); tick();

    // Reset during CAPTURE of a read: outputs clear, no ack
    req0 = 1'b1; wr0 = 1'b0; addr0 = 5'd9;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk_reset_outs("midrst");
    req0 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    issue(0, 1'b1, 5'd4, 8'h55, 2);
    issue(1, 1'b1, 5'd5, 8'h66, 5);
    wait_ack(0, 10);
    wait_ack(1, 10);

    // Grant counters: 5 grants to port 0, 1 to port 1 after a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) xfer(0, 1'b1, 5'(i), 8'(i));
    xfer(1, 1'b1, 5'd6, 8'h77);
`ifdef MEM_ARB_GRANT_CNT_EN
    chk("cnt0_sat", 32'(gnt_cnt0), 3);
    chk("cnt1", 32'(gnt_cnt1), 1);
`endif

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
